riscv_custom_accum_unit: RTL and testbench

Per-hart accumulator execution unit attached to the RISC-V core's custom-instruction port. It sits directly downstream of the core's `CustomInstr` output bundle and returns `CustomInstr_result` one cycle later. It gives each hardware thread (hart) a private 32-bit accumulator and operation counter, driven by `custom-0` instructions. The unit is fully pipelined with no backpressure: one instruction per cycle from any hart.

---
 rtl/riscv_custom_accum_unit.sv | 94 +++++++++
 tb/tb_riscv_custom_accum_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/riscv_custom_accum_unit.sv
// riscv_custom_accum_unit: per-hart accumulator/counter unit on the custom-0 port.
// Define RISCV_CUSTOM_ACCUM_SAT_EN for signed saturating accumulate adds.
module riscv_custom_accum_unit #(
  parameter int         HART_COUNT     = 2,
  parameter int         HID_WIDTH      = 1,
  parameter logic [4:0] CUSTOM0_OPCODE = 5'h02
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 CustomInstr_valid_in,
  input  logic [HID_WIDTH-1:0] CustomInstr_hid_in,
  input  logic [4:0]           CustomInstr_major_opcode_in,
  input  logic [2:0]           CustomInstr_minor_opcode_in,
  input  logic [31:0]          CustomInstr_op1_in,
  input  logic [31:0]          CustomInstr_op2_in,
  input  logic [31:0]          CustomInstr_imm_in,
  input  logic [6:0]           CustomInstr_funct7_in,
  output logic [31:0]          CustomInstr_result_out
);
  logic [31:0]          acc     [HART_COUNT];
  logic [15:0]          cnt     [HART_COUNT];
  logic [31:0]          eff     [HART_COUNT];
  logic [31:0]          acc_nxt [HART_COUNT];
  logic [15:0]          cnt_nxt [HART_COUNT];
  logic                 pend_valid;
  logic [HID_WIDTH-1:0] pend_hid;
  logic [31:0]          pend_prod;
  logic                 ok, modifying;
  logic [2:0]           minor;
  logic [31:0]          eff_sel, result_nxt;
  logic [15:0]          cnt_sel;
  logic                 unused_funct7;

  assign unused_funct7 = ^CustomInstr_funct7_in;
  assign minor = CustomInstr_minor_opcode_in;

  function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
`ifdef RISCV_CUSTOM_ACCUM_SAT_EN
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31] && s[31] != a[31]) ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s;
`else
    return a + b;
`endif
  endfunction

  // eff folds the in-flight MAC product so every op sees program order
  always_comb begin
    ok = CustomInstr_valid_in && CustomInstr_major_opcode_in == CUSTOM0_OPCODE &&
         32'(CustomInstr_hid_in) < HART_COUNT;
    modifying = minor == 3'd0 || minor == 3'd1 || minor == 3'd3;
    eff_sel = '0;
    cnt_sel = '0;
    for (int h = 0; h < HART_COUNT; h++) begin
      eff[h] = (pend_valid && pend_hid == HID_WIDTH'(h)) ? add32(acc[h], pend_prod) : acc[h];
      acc_nxt[h] = eff[h];
      cnt_nxt[h] = cnt[h];
      if (ok && CustomInstr_hid_in == HID_WIDTH'(h)) begin
        eff_sel = eff[h];
        cnt_sel = cnt[h];
        acc_nxt[h] = minor == 3'd0 ? CustomInstr_op1_in :
                     minor == 3'd1 ? add32(eff[h], CustomInstr_op2_in + CustomInstr_imm_in) :
                     minor == 3'd5 ? '0 : eff[h];
        cnt_nxt[h] = minor == 3'd5 ? '0 :
                     (modifying && cnt[h] != 16'hFFFF) ? cnt[h] + 16'd1 : cnt[h];
      end
    end
    result_nxt = !ok ? '0 :
                 (minor == 3'd0 || minor == 3'd2) ? eff_sel :
                 minor == 3'd4 ? {16'b0, cnt_sel} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < HART_COUNT; h++) begin
        acc[h] <= '0;
        cnt[h] <= '0;
      end
      pend_valid <= 1'b0;
      pend_hid <= '0;
      pend_prod <= '0;
      CustomInstr_result_out <= '0;
    end else begin
      for (int h = 0; h < HART_COUNT; h++) begin
        acc[h] <= acc_nxt[h];
        cnt[h] <= cnt_nxt[h];
      end
      pend_valid <= ok && minor == 3'd3;
      pend_hid <= CustomInstr_hid_in;
      pend_prod <= CustomInstr_op1_in * CustomInstr_op2_in;
      CustomInstr_result_out <= result_nxt;
    end
  end
endmodule

// File: tb/tb_riscv_custom_accum_unit.sv
// tb_riscv_custom_accum_unit: directed scoreboard bench for the accumulator unit.
module tb_riscv_custom_accum_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [0:0]  hid = '0;
  logic [4:0]  major = '0;
  logic [2:0]  minor = '0;
  logic [31:0] op1 = '0, op2 = '0, imm = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] result;
  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] SAT_EXP =
`ifdef RISCV_CUSTOM_ACCUM_SAT_EN
    32'h7FFF_FFFF;
`else
    32'h8000_0000;
`endif

  riscv_custom_accum_unit dut (
    .clk(clk), .rst_n(rst_n),
    .CustomInstr_valid_in(valid), .CustomInstr_hid_in(hid),
    .CustomInstr_major_opcode_in(major), .CustomInstr_minor_opcode_in(minor),
    .CustomInstr_op1_in(op1), .CustomInstr_op2_in(op2), .CustomInstr_imm_in(imm),
    .CustomInstr_funct7_in(funct7), .CustomInstr_result_out(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] e);
    checks++;
    assert (result === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, result, e);
    end
  endtask

  task automatic pop_check();
    if (exp_q.size() != 0) check(tag_q.pop_front(), exp_q.pop_front());
  endtask

  // issue one op at the negedge, scoring the previous op's result first
  task automatic step(input string tag, input logic v, input logic [4:0] mj, input logic h,
                      input logic [2:0] mn, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] i, input logic [31:0] e);
    @(negedge clk);
    pop_check();
    valid = v; major = mj; hid = h; minor = mn; op1 = a; op2 = b; imm = i;
    funct7 = 7'($urandom);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic op(input string tag, input logic h, input logic [2:0] mn,
                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] i,
                    input logic [31:0] e);
    step(tag, 1'b1, 5'h02, h, mn, a, b, i, e);
  endtask

  initial begin
    #1 check("reset_result", 32'h0);
    repeat (2) @(negedge clk);
    check("reset_hold", 32'h0);
    rst_n = 1'b1;
    op("read_h0_init", 1'b0, 3'd2, 0, 0, 0, 32'd0);
    op("read_h1_init", 1'b1, 3'd2, 0, 0, 0, 32'd0);
    op("load_h0", 1'b0, 3'd0, 32'd5, 0, 0, 32'd0);
    op("add_h0", 1'b0, 3'd1, 0, 32'd3, 32'd2, 32'd0);
    op("read_h0_10", 1'b0, 3'd2, 0, 0, 0, 32'd10);
    op("read_h1_0", 1'b1, 3'd2, 0, 0, 0, 32'd0);
    op("count_h0_2", 1'b0, 3'd4, 0, 0, 0, 32'd2);
    op("mac_h1", 1'b1, 3'd3, 32'd6, 32'd7, 0, 32'd0);
    op("read_h1_42", 1'b1, 3'd2, 0, 0, 0, 32'd42);
    op("mac_h1_b", 1'b1, 3'd3, 32'd2, 32'd2, 0, 32'd0);
    op("load_h1_old", 1'b1, 3'd0, 32'd1, 0, 0, 32'd46);
    op("read_h1_1", 1'b1, 3'd2, 0, 0, 0, 32'd1);
    op("count_h1_3", 1'b1, 3'd4, 0, 0, 0, 32'd3);
    op("clear_h0", 1'b0, 3'd5, 0, 0, 0, 32'd0);
    op("clear_h1", 1'b1, 3'd5, 0, 0, 0, 32'd0);
    op("mac_h0", 1'b0, 3'd3, 32'd2, 32'd3, 0, 32'd0);
    op("add_h1", 1'b1, 3'd1, 0, 32'd4, 0, 32'd0);
    op("read_h0_6", 1'b0, 3'd2, 0, 0, 0, 32'd6);
    op("read_h1_4", 1'b1, 3'd2, 0, 0, 0, 32'd4);
    op("mac_h0_col", 1'b0, 3'd3, 32'd1, 32'd1, 0, 32'd0);
    op("add_h0_col", 1'b0, 3'd1, 0, 32'd1, 0, 32'd0);
    op("read_h0_8", 1'b0, 3'd2, 0, 0, 0, 32'd8);
    step("bad_major", 1'b1, 5'h0A, 1'b0, 3'd0, 32'd99, 0, 0, 32'd0);
    step("bad_major_read", 1'b1, 5'h0A, 1'b0, 3'd2, 0, 0, 0, 32'd0);
    op("minor7", 1'b0, 3'd7, 32'd77, 32'd77, 32'd77, 32'd0);
    step("invalid_read", 1'b0, 5'h02, 1'b0, 3'd2, 0, 0, 0, 32'd0);
    op("read_h0_kept", 1'b0, 3'd2, 0, 0, 0, 32'd8);
    op("count_h0_3", 1'b0, 3'd4, 0, 0, 0, 32'd3);
    op("clear_h0_b", 1'b0, 3'd5, 0, 0, 0, 32'd0);
    op("read_h0_clr", 1'b0, 3'd2, 0, 0, 0, 32'd0);
    op("count_h0_clr", 1'b0, 3'd4, 0, 0, 0, 32'd0);
    op("load_h0_max", 1'b0, 3'd0, 32'h7FFF_FFFF, 0, 0, 32'd0);
    op("add_h0_ovf", 1'b0, 3'd1, 0, 32'd1, 0, 32'd0);
    op("read_h0_ovf", 1'b0, 3'd2, 0, 0, 0, SAT_EXP);
    op("mac_h1_rst", 1'b1, 3'd3, 32'd3, 32'd3, 0, 32'd0);
    @(negedge clk);
    pop_check();
    valid = 1'b0;
    rst_n = 1'b0;
    #1 check("reset_mid_mac", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    op("read_h1_after_rst", 1'b1, 3'd2, 0, 0, 0, 32'd0);
    op("read_h0_after_rst", 1'b0, 3'd2, 0, 0, 0, 32'd0);
    op("count_h1_after_rst", 1'b1, 3'd4, 0, 0, 0, 32'd0);
    step("idle", 1'b0, 5'h02, 1'b0, 3'd2, 0, 0, 0, 32'd0);
    @(negedge clk);
    pop_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
